dma_byp_out_arb: RTL

- Round-robin arbiter that merges NUM_SRC descriptor bypass-out streams onto one downstream bypass-out consumer. Each stream carries a descriptor, a consumer index and a vld/rdy handshake; typical sources are H2C and C2H bypass-out.
- Single-beat transfers; arbitration decides on every beat, subject to a per-source burst limit.
- Output is registered and tagged with the source index. Per-source grant counters support debug.

---
 rtl/dma_byp_pkg.sv | 32 +++
 rtl/dma_rr_arb.sv | 46 ++++
 rtl/dma_byp_out_arb.sv | 115 +++++++++++
 3 files changed

// File: rtl/dma_byp_pkg.sv
// Shared types and round-robin helper for the bypass-out arbiter.
// rr_pick scans circularly from last_ptr+1 and ends on last_ptr.
package dma_byp_pkg;

    localparam int DSC_W_DEF  = 256;
    localparam int CIDX_W_DEF = 16;
    localparam int MAX_SRC    = 8;

    typedef logic [255:0] byp_dsc_t;
    typedef logic [15:0]  byp_cidx_t;

    function automatic logic [MAX_SRC-1:0] rr_pick(
        input logic [MAX_SRC-1:0] req,
        input logic [2:0]         last_ptr,
        input int unsigned        n = MAX_SRC
    );
        logic [MAX_SRC-1:0] g;
        logic               found;
        int unsigned        idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_SRC; k++) begin
            idx = (int'(last_ptr) + k) % n;
            if (k <= n && !found && req[idx[2:0]]) begin
                g[idx[2:0]] = 1'b1;
                found       = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/dma_rr_arb.sv
// Round-robin picker with burst limiter; the caller owns the
// last_ptr / burst_cnt registers and loads them on a grant.
module dma_rr_arb
    import dma_byp_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int MAX_BURST = 4,
    parameter int SW        = $clog2(NUM_SRC),
    parameter int BW        = $clog2(MAX_BURST + 1)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic               ld,
    input  logic               own,
    input  logic [SW-1:0]      last_ptr,
    input  logic [BW-1:0]      burst_cnt,
    output logic [NUM_SRC-1:0] gnt,
    output logic [SW-1:0]      gnt_idx,
    output logic [BW-1:0]      nxt_burst
);

    logic               w_hold;
    logic [MAX_SRC-1:0] w_pick;

    // own is low until the first grant so source 0 wins out of reset
    assign w_hold = own && req[last_ptr] &&
                    (burst_cnt < BW'(MAX_BURST - 1));

    assign w_pick = rr_pick(MAX_SRC'(req), 3'(last_ptr), NUM_SRC);

    always_comb begin
        gnt = '0;
        if (ld) begin
            if (w_hold) gnt[last_ptr] = 1'b1;
            else        gnt = w_pick[NUM_SRC-1:0];
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (gnt[i]) gnt_idx = SW'(i);
    end

    assign nxt_burst = w_hold ? burst_cnt + 1'b1 : '0;

endmodule

// File: rtl/dma_byp_out_arb.sv
// Merges NUM_SRC bypass-out descriptor streams onto one registered
// output tagged with its source, with per-source grant counters.
module dma_byp_out_arb
    import dma_byp_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int DSC_W     = DSC_W_DEF,
    parameter int CIDX_W    = CIDX_W_DEF,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 32,
    parameter int SW        = $clog2(NUM_SRC)
) (
    input  logic                      user_clk,
    input  logic                      user_reset,
    input  logic [NUM_SRC*DSC_W-1:0]  s_dsc,
    input  logic [NUM_SRC*CIDX_W-1:0] s_cidx,
    input  logic [NUM_SRC-1:0]        s_vld,
    output logic [NUM_SRC-1:0]        s_rdy,
    output logic [DSC_W-1:0]          m_dsc,
    output logic [CIDX_W-1:0]         m_cidx,
    output logic [SW-1:0]             m_src,
    output logic                      m_vld,
    input  logic                      m_rdy,
    input  logic                      cnt_clr,
    output logic [NUM_SRC*CNT_W-1:0]  gnt_cnt
);

    localparam int BW = $clog2(MAX_BURST + 1);

    logic               r_vld;
    logic [DSC_W-1:0]   r_dsc;
    logic [CIDX_W-1:0]  r_cidx;
    logic [SW-1:0]      r_src;
    logic               r_own;
    logic [SW-1:0]      r_last;
    logic [BW-1:0]      r_burst;
    logic [CNT_W-1:0]   r_cnt [NUM_SRC];

    logic               w_ld;
    logic               w_xfer;
    logic [NUM_SRC-1:0] w_gnt;
    logic [SW-1:0]      w_idx;
    logic [BW-1:0]      w_nxt_burst;

    assign w_ld   = ~r_vld | m_rdy;
    assign w_xfer = |w_gnt;

    dma_rr_arb #(
        .NUM_SRC   (NUM_SRC),
        .MAX_BURST (MAX_BURST),
        .SW        (SW),
        .BW        (BW)
    ) u_arb (
        .req       (s_vld),
        .ld        (w_ld & ~user_reset),
        .own       (r_own),
        .last_ptr  (r_last),
        .burst_cnt (r_burst),
        .gnt       (w_gnt),
        .gnt_idx   (w_idx),
        .nxt_burst (w_nxt_burst)
    );

    assign s_rdy = w_gnt;

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            r_vld  <= 1'b0;
            r_dsc  <= '0;
            r_cidx <= '0;
            r_src  <= '0;
        end else if (w_xfer) begin
            r_vld  <= 1'b1;
            r_dsc  <= s_dsc[w_idx*DSC_W +: DSC_W];
            r_cidx <= s_cidx[w_idx*CIDX_W +: CIDX_W];
            r_src  <= w_idx;
        end else if (w_ld) begin
            r_vld  <= 1'b0;
        end
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            r_own   <= 1'b0;
            r_last  <= SW'(NUM_SRC - 1);
            r_burst <= '0;
        end else if (w_xfer) begin
            r_own   <= 1'b1;
            r_last  <= w_idx;
            r_burst <= w_nxt_burst;
        end
    end

    // clear beats a same-cycle grant
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            for (int i = 0; i < NUM_SRC; i++) r_cnt[i] <= '0;
        end else if (cnt_clr) begin
            for (int i = 0; i < NUM_SRC; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++)
                if (w_gnt[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_cnt
        assign gnt_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
    end

    assign m_vld  = r_vld;
    assign m_dsc  = r_dsc;
    assign m_cidx = r_cidx;
    assign m_src  = r_src;

endmodule
